// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM encoding, frame field
// widths and the default frame start marker.
package program_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 16;
    localparam int unsigned LANE_W = 2;

    localparam logic [BYTE_W-1:0] SYNC_BYTE_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } loader_state_e;

    // Frame length field as received: low byte first, then high byte.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } len_t;

    // States in which the CPU must be kept in reset.
    function automatic logic holds_cpu(input loader_state_e s);
        return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Byte-lane assembly of little-endian 32-bit words with a running XOR checksum
// over every payload byte since the last start pulse.
module program_loader_word_assembler
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              byte_en_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_c_o,
    output logic              word_ready_c_o,
    output logic [BYTE_W-1:0] chk_o
);

    localparam int unsigned LOW_W = WORD_W - BYTE_W;

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [LOW_W-1:0]  low_q,  low_d;
    logic [BYTE_W-1:0] chk_q,  chk_d;

    // The fourth byte completes the word in the same cycle it is accepted.
    assign word_ready_c_o = byte_en_i && (lane_q == {LANE_W{1'b1}});
    assign word_c_o       = {byte_i, low_q};
    assign chk_o          = chk_q;

    always_comb begin
        lane_d = lane_q;
        low_d  = low_q;
        chk_d  = chk_q;
        if (start_i) begin
            lane_d = '0;
            low_d  = '0;
            chk_d  = '0;
        end else if (byte_en_i) begin
            lane_d = lane_q + LANE_W'(1);
            low_d  = {byte_i, low_q[LOW_W-1:BYTE_W]};
            chk_d  = chk_q ^ byte_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            low_q  <= '0;
            chk_q  <= '0;
        end else begin
            lane_q <= lane_d;
            low_q  <= low_d;
            chk_q  <= chk_d;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream program loader: writes assembled words into program memory
// from address 0, holds the CPU in reset while loading, then flags done or err.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned       PC_WIDTH  = 12,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BYTE_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                clear,
    output logic                pm_w_en,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic [WORD_W-1:0]   pm_wdata,
    output logic                cpu_hold,
    output logic                done,
    output logic                err
);

    localparam int unsigned CNT_W    = PC_WIDTH + 1;
    localparam int unsigned CAPACITY = 32'(1) << PC_WIDTH;

    loader_state_e       state_q, state_d;
    len_t                len_q, len_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                pm_w_en_q, pm_w_en_d;
    logic [PC_WIDTH-1:0] pm_addr_q, pm_addr_d;
    logic [WORD_W-1:0]   pm_wdata_q, pm_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                fire_c;
    logic                start_c;
    logic                data_fire_c;
    logic [LEN_W-1:0]    len_full_c;
    logic [WORD_W-1:0]   word_c;
    logic                word_ready_c;
    logic [BYTE_W-1:0]   chk;

    assign fire_c      = in_valid && in_ready_q;
    assign start_c     = fire_c && (state_q == ST_LEN1);
    assign data_fire_c = fire_c && (state_q == ST_DATA);
    assign len_full_c  = {in_data, len_q.lo};

    program_loader_word_assembler u_asm (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_c),
        .byte_en_i      (data_fire_c),
        .byte_i         (in_data),
        .word_c_o       (word_c),
        .word_ready_c_o (word_ready_c),
        .chk_o          (chk)
    );

    // Next state plus next values of every registered output.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        pm_w_en_d  = 1'b0;
        pm_addr_d  = pm_addr_q;
        pm_wdata_d = pm_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (fire_c && (in_data == SYNC_BYTE)) state_d = ST_LEN0;
            end
            ST_LEN0: begin
                if (fire_c) begin
                    len_d.lo = in_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (fire_c) begin
                    len_d.hi = in_data;
                    cnt_d    = '0;
                    if (len_full_c == '0)                  state_d = ST_CHK;
                    else if (32'(len_full_c) > CAPACITY)   state_d = ST_ERR;
                    else                                   state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (word_ready_c) begin
                    pm_w_en_d  = 1'b1;
                    pm_addr_d  = cnt_q[PC_WIDTH-1:0];
                    pm_wdata_d = word_c;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (32'(cnt_d) == 32'(len_q)) state_d = ST_CHK;
                end
            end
            ST_CHK: begin
                if (fire_c) state_d = (in_data == chk) ? ST_DONE : ST_ERR;
            end
            ST_DONE, ST_ERR: begin
                if (clear) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = !((state_d == ST_DONE) || (state_d == ST_ERR));
        cpu_hold_d = holds_cpu(state_d);
        done_d     = (state_d == ST_DONE);
        err_d      = (state_d == ST_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            pm_w_en_q  <= 1'b0;
            pm_addr_q  <= '0;
            pm_wdata_q <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            pm_w_en_q  <= pm_w_en_d;
            pm_addr_q  <= pm_addr_d;
            pm_wdata_q <= pm_wdata_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign pm_w_en  = pm_w_en_q;
    assign pm_addr  = pm_addr_q;
    assign pm_wdata = pm_wdata_q;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frames are built from word lists, expected writes,
// hold levels and final status come from the frame rules, not from the DUT.
module tb_program_loader;

    localparam int CAP = 4096;
    localparam logic [7:0] SYNC = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        clear;
    logic        pm_w_en;
    logic [11:0] pm_addr;
    logic [31:0] pm_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    program_loader #(.PC_WIDTH(12), .SYNC_BYTE(8'hA5)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clear    (clear),
        .pm_w_en  (pm_w_en),
        .pm_addr  (pm_addr),
        .pm_wdata (pm_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] b;
        int         wr;
        bit         hold;
    } tx_t;

    tx_t         tx[$];
    logic [31:0] words[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;
    int          wr_base;
    bit          exp_done;
    int          exp_writes;

    always @(negedge clk) if (pm_w_en === 1'b1) wr_count++;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b, input int wr, input bit hold);
        tx.push_back('{b: b, wr: wr, hold: hold});
    endtask

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic push_junk(input int n);
        logic [7:0] r;
        for (int i = 0; i < n; i++) begin
            r = 8'($urandom);
            if (r == SYNC) r = 8'h5A;
            push(r, -1, 1'b0);
        end
    endtask

    // mode 0: correct checksum, 1: checksum forced to val, 2: correct ^ val
    task automatic build(input int n, input int mode, input logic [7:0] val);
        logic [7:0] c;
        logic [7:0] bv;
        logic [7:0] cb;
        c = 8'h00;
        push(SYNC, -1, 1'b1);
        push(8'(n), -1, 1'b1);
        if (n > CAP) begin
            push(8'(n >> 8), -1, 1'b0);
            exp_done   = 1'b0;
            exp_writes = 0;
            return;
        end
        push(8'(n >> 8), -1, 1'b1);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                bv = 8'(words[w] >> (8 * k));
                c  = c ^ bv;
                push(bv, (k == 3) ? w : -1, 1'b1);
            end
        end
        cb = (mode == 0) ? c : (mode == 1) ? val : (c ^ val);
        push(cb, -1, 1'b0);
        exp_done   = (cb == c);
        exp_writes = n;
    endtask

    task automatic play(input int upto, input bit gaps);
        int wt;
        for (int i = 0; i < upto; i++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                check("idle_no_write", 32'(pm_w_en), 32'd0);
            end
            in_valid = 1'b1;
            in_data  = tx[i].b;
            wt = 0;
            while (in_ready !== 1'b1) begin
                @(negedge clk);
                wt++;
                if (wt > 50) begin
                    check("in_ready_wait", 32'(in_ready), 32'd1);
                    in_valid = 1'b0;
                    return;
                end
            end
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            if (tx[i].wr >= 0) begin
                check("wr_en", 32'(pm_w_en), 32'd1);
                check("wr_addr", 32'(pm_addr), 32'(tx[i].wr));
                check("wr_data", pm_wdata, words[tx[i].wr]);
            end else begin
                check("no_write", 32'(pm_w_en), 32'd0);
            end
            check("cpu_hold", 32'(cpu_hold), 32'(tx[i].hold));
        end
    endtask

    task automatic run(input bit gaps);
        wr_base = wr_count;
        play(tx.size(), gaps);
        check("done", 32'(done), 32'(exp_done));
        check("err", 32'(err), 32'(!exp_done));
        check("ready_end", 32'(in_ready), 32'd0);
        check("hold_end", 32'(cpu_hold), 32'd0);
        check("write_count", 32'(wr_count - wr_base), 32'(exp_writes));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_done", 32'(done), 32'd0);
        check("clear_err", 32'(err), 32'd0);
        check("clear_ready", 32'(in_ready), 32'd1);
        tx.delete();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        clear    = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_wen", 32'(pm_w_en), 32'd0);
        check("rst_addr", 32'(pm_addr), 32'd0);
        check("rst_wdata", pm_wdata, 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);

        // Two-word frame with correct checksum C0.
        words = '{32'h00000013, 32'h00400093};
        build(2, 0, 8'h00);
        check("model_chk_c0", 32'(tx[tx.size()-1].b), 32'h000000C0);
        run(1'b0);

        // Same frame with checksum 00.
        build(2, 1, 8'h00);
        run(1'b1);

        // Leading junk FF 12 is discarded before SYNC.
        push(8'hFF, -1, 1'b0);
        push(8'h12, -1, 1'b0);
        words = '{32'h12345678};
        build(1, 0, 8'h00);
        run(1'b1);

        // Empty frame.
        words.delete();
        build(0, 0, 8'h00);
        run(1'b1);

        // Oversize length 4097.
        build(4097, 0, 8'h00);
        run(1'b0);

        // Reset after six payload bytes.
        fill_words(2);
        build(2, 0, 8'h00);
        play(9, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(in_ready), 32'd0);
        check("midrst_wen", 32'(pm_w_en), 32'd0);
        check("midrst_addr", 32'(pm_addr), 32'd0);
        check("midrst_wdata", pm_wdata, 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        rst = 1'b0;
        tx.delete();
        fill_words(3);
        build(3, 0, 8'h00);
        run(1'b1);

        // Random frames with stalls, junk prefixes and occasional bad checksum.
        for (int r = 0; r < 8; r++) begin
            fill_words($urandom_range(1, 6));
            push_junk($urandom_range(0, 2));
            if ($urandom_range(0, 3) == 0) build(words.size(), 2, 8'($urandom_range(1, 255)));
            else                           build(words.size(), 0, 8'h00);
            run(1'b1);
        end

        // Full-capacity frame: addresses 0..4095.
        fill_words(CAP);
        build(CAP, 0, 8'h00);
        run(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side counterpart of the CPU program memory.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words.
- Writes each word into program memory through its w_en/addr/wdata write port, starting at address 0.
- Holds the CPU in reset while loading, then reports success or a checksum/length error.

Parameters:
- PC_WIDTH, 12, program memory address width; capacity is 2**PC_WIDTH words.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; all logic is posedge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle. A transfer occurs when in_valid && in_ready.
- clear  input  1  one-cycle pulse that returns the loader from DONE or ERR to IDLE.
- pm_w_en  output  1  program memory write strobe, one cycle per word.
- pm_addr  output  PC_WIDTH  word address for the write.
- pm_wdata  output  32  word to write.
- cpu_hold  output  1  keeps the CPU in reset while loading.
- done  output  1  load completed with a good checksum.
- err  output  1  checksum mismatch or oversize length.

Behaviour:
- Reset is synchronous and active-high on rst, sampled at posedge clk. Reset values:
  - state = IDLE.
  - in_ready = 0 during the reset cycle, 1 afterwards.
  - pm_w_en = 0, pm_addr = 0, pm_wdata = 0.
  - cpu_hold = 0, done = 0, err = 0.
  - Word count, byte lane, address and checksum cleared.
- Reset mid-load aborts the frame. Program memory contents already written are left as-is.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then 4*N payload bytes (LSB of each word first), then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = XOR of all payload bytes.
- FSM states:
  - IDLE: accept bytes. Non-SYNC bytes are discarded. SYNC -> LEN0. cpu_hold = 0.
  - LEN0: capture LEN_LO -> LEN1. cpu_hold = 1 from this state through CHK.
  - LEN1: capture LEN_HI.
    - If N == 0 -> CHK.
    - If N > 2**PC_WIDTH -> ERR.
    - Else -> DATA, with addr = 0 and lane = 0.
  - DATA:
    - Each accepted byte goes into lane[1:0] of the assembly register and is XORed into the checksum; lane increments.
    - On acceptance of lane 3: pm_wdata = the assembled word and pm_w_en = 1 in the next cycle, with pm_addr = the current word address. The address then increments.
    - After the N-th word is accepted -> CHK.
    - in_ready stays 1 during the write cycle; writes never stall the stream.
  - CHK: compare the accepted byte with the running XOR. Equal -> DONE, else -> ERR.
  - DONE: done = 1, cpu_hold = 0, in_ready = 0. clear -> IDLE and done drops.
  - ERR: err = 1, cpu_hold = 0, in_ready = 0. clear -> IDLE and err drops.
- clear in any state other than DONE/ERR is ignored.
- Latency: pm_w_en asserts exactly 1 cycle after the 4th byte of a word is accepted. done/err assert 1 cycle after CHK is accepted.
- Address width: a word counter of PC_WIDTH+1 bits. N == 2**PC_WIDTH is legal; the last word is written at 2**PC_WIDTH-1. pm_addr never wraps within a frame.
- in_valid low stalls the FSM with no state change. A partial word is held indefinitely.
- A SYNC byte inside DATA is treated as payload, not as a resync.

Decomposition:
- Shared header, alongside the existing common library:
  - Loader state encodings: IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR.
  - SYNC_BYTE default.
  - Frame field widths: LEN = 16, lane = 2.
- Natural sub-module: loader_word_assembler, a byte-lane shift/assembly register plus running XOR and a word_ready pulse.
- The FSM, word counter and address counter stay in program_loader.

Test Plan:
- Send A5, 02, 00, then 13 00 00 00, 93 00 40 00, then CHK = 13^93^40 = C0.
  - Expect pm_w_en pulses at addr 0 with 00000013 and at addr 1 with 00400093.
  - done = 1; cpu_hold high from LEN0 to CHK.
- Same frame with CHK = 00 -> both words written, err = 1, done = 0. Pulse clear -> IDLE, err = 0.
- Send FF, 12, A5, 01, 00, 78 56 34 12, 08 -> leading FF and 12 are ignored. Write addr 0 = 12345678; done = 1.
- Send A5, 00, 00, 00 (N = 0) -> no pm_w_en; done = 1.
- Send A5, 01, 10 with PC_WIDTH = 12 (N = 4097 > 4096) -> ERR and no writes. A length of exactly 4096 with a valid payload writes addr 0..4095 and gives done = 1.
- Assert rst for 1 cycle after 6 payload bytes -> all outputs return to reset values. A fresh frame then loads correctly from addr 0.
- Randomly deassert in_valid mid-word -> the word value and address are unchanged, and the write is delayed until the 4th byte is accepted.
